// File: rtl/ula_io_pkg.sv
// Shared constants and types for the ULA I/O slice: frame timing,
// port decode bit and keyboard matrix geometry.
package ula_io_pkg;

  localparam int FRAME_LEN    = 69888;
  localparam int INT_LEN      = 32;
  localparam int ULA_PORT_BIT = 0;
  localparam int KEY_ROWS     = 8;
  localparam int KEY_COLS     = 5;
  localparam int CNT_W        = $clog2(FRAME_LEN);

  typedef logic [CNT_W-1:0] count_t;

  typedef struct packed {
    logic [2:0] border;
    logic       mic;
    logic       speaker;
  } port_out_t;

endpackage

// File: rtl/frame_timer.sv
// Frame counter in cep units plus the active-low frame interrupt with
// acknowledge-clear. The interrupt only falls on a wrap to count 0.
module frame_timer
  import ula_io_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   cep,
  input  logic   ack,
  output logic   int_n,
  output count_t count
);

  count_t count_reg, count_next;
  logic   int_reg, int_next;
  logic   wrap;

  // Falling only on the wrap edge keeps the reset frame's slot silent and
  // lets an acknowledge hold int high until the next wrap.
  always_comb begin
    count_next = count_reg;
    int_next   = int_reg;
    wrap       = (count_reg == count_t'(FRAME_LEN - 1));
    if (cep) begin
      count_next = wrap ? '0 : count_reg + count_t'(1);
      if (wrap) begin
        int_next = 1'b0;
      end else if (ack || count_next == count_t'(INT_LEN)) begin
        int_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
      int_reg   <= 1'b1;
    end else begin
      count_reg <= count_next;
      int_reg   <= int_next;
    end
  end

  assign int_n = int_reg;
  assign count = count_reg;

endmodule

// File: rtl/ula_io.sv
// ULA I/O: port 0xFE decode, border/mic/speaker register, keyboard
// column reduction, registered CPU read data and frame interrupt.
module ula_io
  import ula_io_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cep,
  input  logic                         iorq,
  input  logic                         m1,
  input  logic                         rd,
  input  logic                         wr,
  input  logic [15:0]                  a,
  input  logic [7:0]                   di,
  output logic [7:0]                   do_data,
  output logic                         int_n,
  input  logic [KEY_ROWS*KEY_COLS-1:0] keys,
  input  logic                         ear,
  output logic [2:0]                   border,
  output logic                         mic,
  output logic                         speaker
);

  logic                               sel;
  logic                               ack;
  logic [KEY_COLS-1:0]                col;
  logic [KEY_COLS-1:0][KEY_ROWS-1:0]  col_terms;
  logic [7:0]                         do_reg, do_next;
  port_out_t                          port_reg, port_next;
  logic                               write_done_reg, write_done_next;
  count_t                             frame_count;
  logic                               unused_ok;

  assign sel = !iorq && m1 && !a[ULA_PORT_BIT];
  assign ack = !iorq && !m1;

  // A row whose address line is high contributes all ones to the AND.
  generate
    for (genvar gi = 0; gi < KEY_COLS; gi++) begin : g_col
      for (genvar gj = 0; gj < KEY_ROWS; gj++) begin : g_row
        assign col_terms[gi][gj] = a[8+gj] | keys[KEY_COLS*gj+gi];
      end
      assign col[gi] = &col_terms[gi];
    end
  endgenerate

  always_comb begin
    do_next         = do_reg;
    port_next       = port_reg;
    write_done_next = write_done_reg;
    if (cep) begin
      do_next = (sel && !rd) ? {1'b1, ear, 1'b1, col} : 8'hFF;
      if (iorq) begin
        write_done_next = 1'b0;
      end else if (sel && !wr && !write_done_reg) begin
        port_next.border  = di[2:0];
        port_next.mic     = di[3];
        port_next.speaker = di[4];
        write_done_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      do_reg         <= 8'hFF;
      port_reg       <= '0;
      write_done_reg <= 1'b0;
    end else begin
      do_reg         <= do_next;
      port_reg       <= port_next;
      write_done_reg <= write_done_next;
    end
  end

  frame_timer u_timer (
    .clock (clock),
    .reset (reset),
    .cep   (cep),
    .ack   (ack),
    .int_n (int_n),
    .count (frame_count)
  );

  assign do_data   = do_reg;
  assign border    = port_reg.border;
  assign mic       = port_reg.mic;
  assign speaker   = port_reg.speaker;
  assign unused_ok = &{1'b0, a[7:1], frame_count};

endmodule
